// File: rtl/mac_dot_sequencer_if.sv
// Bundle of command, operand-memory, MAC and result signals for the dot-product sequencer.
// The slave modport is the sequencer's view; master is the surrounding host/memory/MAC side.
interface mac_dot_sequencer_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8,
    parameter int ACC_WIDTH  = 40
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [ADDR_WIDTH-1:0] cmd_base_a;
    logic [ADDR_WIDTH-1:0] cmd_base_b;
    logic [ADDR_WIDTH:0]   cmd_len;

    logic                  mem_rd_en;
    logic [ADDR_WIDTH-1:0] mem_addr_a;
    logic [ADDR_WIDTH-1:0] mem_addr_b;
    logic [DATA_WIDTH-1:0] mem_rdata_a;
    logic [DATA_WIDTH-1:0] mem_rdata_b;

    logic                  mac_start;
    logic                  mac_clr_acc;
    logic [DATA_WIDTH-1:0] mac_a;
    logic [DATA_WIDTH-1:0] mac_b;
    logic                  mac_ready;
    logic [ACC_WIDTH-1:0]  mac_acc;

    logic                  res_valid;
    logic                  res_ready;
    logic [ACC_WIDTH-1:0]  res_data;
    logic                  res_err;

    modport slave (
        input  cmd_valid, cmd_base_a, cmd_base_b, cmd_len,
        output cmd_ready,
        output mem_rd_en, mem_addr_a, mem_addr_b,
        input  mem_rdata_a, mem_rdata_b,
        output mac_start, mac_clr_acc, mac_a, mac_b,
        input  mac_ready, mac_acc,
        output res_valid, res_data, res_err,
        input  res_ready
    );

    modport master (
        output cmd_valid, cmd_base_a, cmd_base_b, cmd_len,
        input  cmd_ready,
        input  mem_rd_en, mem_addr_a, mem_addr_b,
        output mem_rdata_a, mem_rdata_b,
        input  mac_start, mac_clr_acc, mac_a, mac_b,
        output mac_ready, mac_acc,
        input  res_valid, res_data, res_err,
        output res_ready
    );
endinterface

// File: rtl/mac_dot_sequencer.sv
// Command-driven controller: one signed dot product per command on an external MAC unit,
// operands fetched from a dual-read memory, result returned on a valid/ready port.
module mac_dot_sequencer #(
    parameter int DATA_WIDTH     = 16,
    parameter int ADDR_WIDTH     = 8,
    parameter int ACC_WIDTH      = 40,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic abort,
    output logic busy,
    mac_dot_sequencer_if.slave bus
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FETCH,
        S_CAPTURE,
        S_ISSUE,
        S_WAIT,
        S_SETTLE,
        S_RESULT
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] base_a_q, base_a_d;
    logic [ADDR_WIDTH-1:0] base_b_q, base_b_d;
    logic [ADDR_WIDTH:0]   len_q, len_d;
    logic [ADDR_WIDTH:0]   idx_q, idx_d;
    logic [DATA_WIDTH-1:0] mac_a_q, mac_a_d;
    logic [DATA_WIDTH-1:0] mac_b_q, mac_b_d;
    logic [TW-1:0]         tmo_q, tmo_d;
    logic                  err_q, err_d;
    logic [ACC_WIDTH-1:0]  res_data_q, res_data_d;

    logic [ADDR_WIDTH:0]   idx_inc;
    logic [TW-1:0]         tmo_inc;

    assign idx_inc = idx_q + (ADDR_WIDTH + 1)'(1);
    assign tmo_inc = tmo_q + TW'(1);

    always_comb begin
        state_d    = state_q;
        base_a_d   = base_a_q;
        base_b_d   = base_b_q;
        len_d      = len_q;
        idx_d      = idx_q;
        mac_a_d    = mac_a_q;
        mac_b_d    = mac_b_q;
        tmo_d      = tmo_q;
        err_d      = err_q;
        res_data_d = res_data_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    base_a_d = bus.cmd_base_a;
                    base_b_d = bus.cmd_base_b;
                    len_d    = bus.cmd_len;
                    idx_d    = '0;
                    err_d    = 1'b0;
                    state_d  = S_CLEAR;
                end
            end
            S_CLEAR: begin
                state_d = (len_q == '0) ? S_SETTLE : S_FETCH;
            end
            S_FETCH: begin
                state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                mac_a_d = bus.mem_rdata_a;
                mac_b_d = bus.mem_rdata_b;
                state_d = S_ISSUE;
            end
            S_ISSUE: begin
                tmo_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // Completion wins over timeout when both land on the same cycle.
                if (bus.mac_ready) begin
                    idx_d   = idx_inc;
                    state_d = (idx_inc == len_q) ? S_SETTLE : S_FETCH;
                end else begin
                    tmo_d = tmo_inc;
                    if (tmo_inc == TW'(TIMEOUT_CYCLES)) begin
                        err_d   = 1'b1;
                        state_d = S_SETTLE;
                    end
                end
            end
            S_SETTLE: begin
                res_data_d = bus.mac_acc;
                state_d    = S_RESULT;
            end
            S_RESULT: begin
                if (bus.res_ready) begin
                    err_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (abort) begin
            err_d   = 1'b0;
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            base_a_q   <= '0;
            base_b_q   <= '0;
            len_q      <= '0;
            idx_q      <= '0;
            mac_a_q    <= '0;
            mac_b_q    <= '0;
            tmo_q      <= '0;
            err_q      <= 1'b0;
            res_data_q <= '0;
        end else begin
            state_q    <= state_d;
            base_a_q   <= base_a_d;
            base_b_q   <= base_b_d;
            len_q      <= len_d;
            idx_q      <= idx_d;
            mac_a_q    <= mac_a_d;
            mac_b_q    <= mac_b_d;
            tmo_q      <= tmo_d;
            err_q      <= err_d;
            res_data_q <= res_data_d;
        end
    end

    // Address arithmetic is ADDR_WIDTH wide so a full-length vector wraps around memory.
    assign bus.mem_addr_a  = base_a_q + idx_q[ADDR_WIDTH-1:0];
    assign bus.mem_addr_b  = base_b_q + idx_q[ADDR_WIDTH-1:0];
    assign bus.mem_rd_en   = (state_q == S_FETCH);

    assign bus.cmd_ready   = (state_q == S_IDLE);
    assign busy            = (state_q != S_IDLE);

    assign bus.mac_clr_acc = (state_q == S_CLEAR);
    assign bus.mac_start   = (state_q == S_ISSUE);
    assign bus.mac_a       = mac_a_q;
    assign bus.mac_b       = mac_b_q;

    assign bus.res_valid   = (state_q == S_RESULT);
    assign bus.res_data    = res_data_q;
    assign bus.res_err     = err_q & (state_q == S_RESULT);
endmodule

// File: tb/tb_mac_dot_sequencer.sv
// Self-checking bench: behavioural memory + MAC around the sequencer, dot products checked
// against a plain arithmetic reference over the operand arrays.
module tb_mac_dot_sequencer;
    localparam int DW  = 16;
    localparam int AW  = 8;
    localparam int ACW = 40;
    localparam int TMO = 64;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic abort = 1'b0;
    logic busy;

    always #5 clk = ~clk;

    mac_dot_sequencer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ACC_WIDTH(ACW)) bus ();

    mac_dot_sequencer #(
        .DATA_WIDTH    (DW),
        .ADDR_WIDTH    (AW),
        .ACC_WIDTH     (ACW),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .abort(abort),
        .busy (busy),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] mem_a [256];
    logic [DW-1:0] mem_b [256];

    int unsigned fixed_delay = 0;
    int          hang_after  = -1;
    bit          stray_en    = 1'b0;
    bit          mon_clr     = 1'b0;
    logic [AW-1:0] exp_ba = '0;
    logic [AW-1:0] exp_bb = '0;

    logic signed [DW-1:0]  m_pa, m_pb;
    logic signed [ACW-1:0] m_acc;
    int unsigned m_cnt, rnd_d, cur_d;
    logic stray_q;
    int n_start, n_clr, n_rd, clr_at, lat_sum, addr_bad;

    assign cur_d         = (fixed_delay != 0) ? fixed_delay : rnd_d;
    assign bus.mac_ready = (m_cnt == 1) | stray_q;
    assign bus.mac_acc   = m_acc;

    // Environment: registered memory, MAC with programmable completion delay, pulse counters.
    always @(posedge clk) begin
        rnd_d   <= $urandom_range(12, 1);
        stray_q <= stray_en && bus.mem_rd_en;
        if (bus.mem_rd_en) begin
            bus.mem_rdata_a <= mem_a[bus.mem_addr_a];
            bus.mem_rdata_b <= mem_b[bus.mem_addr_b];
        end
        if (bus.mac_clr_acc) m_acc <= '0;
        else if (m_cnt == 1) m_acc <= m_acc + 40'(m_pa) * 40'(m_pb);
        if (m_cnt > 0) m_cnt <= m_cnt - 1;
        if (mon_clr) begin
            n_start <= 0; n_clr <= 0; n_rd <= 0; clr_at <= -1; lat_sum <= 0; addr_bad <= 0;
        end else begin
            if (bus.mac_start) begin
                m_pa <= bus.mac_a;
                m_pb <= bus.mac_b;
                if (hang_after >= 0 && n_start >= hang_after) begin
                    m_cnt   <= 0;
                    lat_sum <= lat_sum + 3 + TMO;
                end else begin
                    m_cnt   <= cur_d;
                    lat_sum <= lat_sum + 3 + int'(cur_d);
                end
                n_start <= n_start + 1;
            end
            if (bus.mac_clr_acc) begin
                n_clr <= n_clr + 1;
                if (n_clr == 0) clr_at <= n_start;
            end
            if (bus.mem_rd_en) begin
                n_rd <= n_rd + 1;
                if (bus.mem_addr_a !== exp_ba + 8'(n_rd) || bus.mem_addr_b !== exp_bb + 8'(n_rd))
                    addr_bad <= addr_bad + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [ACW-1:0] ref_dot(input logic [AW-1:0] ba, input logic [AW-1:0] bb,
                                               input int n);
        logic signed [ACW-1:0] s = '0;
        for (int i = 0; i < n; i++)
            s += 40'($signed(mem_a[8'(ba + i)])) * 40'($signed(mem_b[8'(bb + i)]));
        return s;
    endfunction

    task automatic fill_random();
        for (int i = 0; i < 256; i++) begin
            mem_a[i] = 16'($urandom);
            mem_b[i] = 16'($urandom);
        end
    endtask

    task automatic run_cmd(input string tag, input logic [AW-1:0] ba, input logic [AW-1:0] bb,
                           input int len, input int hang, input bit stray, input int hold,
                           output logic [ACW-1:0] got);
        int n;
        int starts;
        int prods;
        int bad;
        bit terr;
        logic [ACW-1:0] held;
        terr        = (hang >= 0 && hang < len);
        starts      = terr ? hang + 1 : len;
        prods       = terr ? hang : len;
        exp_ba      = ba;
        exp_bb      = bb;
        hang_after  = hang;
        stray_en    = stray;
        bus.res_ready = (hold == 0);
        mon_clr = 1'b1;
        @(posedge clk); #1;
        mon_clr = 1'b0;
        check({tag, "_cmd_ready"}, 64'(bus.cmd_ready), 64'(1));
        bus.cmd_valid  = 1'b1;
        bus.cmd_base_a = ba;
        bus.cmd_base_b = bb;
        bus.cmd_len    = 9'(len);
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        check({tag, "_busy"}, 64'(busy), 64'(1));
        n = 1;
        while (!bus.res_valid && n < 3 + len * (3 + TMO) + 20) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_res_valid"}, 64'(bus.res_valid), 64'(1));
        check({tag, "_latency"}, 64'(n), 64'(3 + lat_sum));
        check({tag, "_res_data"}, 64'(bus.res_data), 64'(ref_dot(ba, bb, prods)));
        check({tag, "_res_err"}, 64'(bus.res_err), 64'(terr));
        check({tag, "_n_start"}, 64'(n_start), 64'(starts));
        check({tag, "_n_rd"}, 64'(n_rd), 64'(starts));
        check({tag, "_n_clr"}, 64'(n_clr), 64'(1));
        check({tag, "_clr_first"}, 64'(clr_at), 64'(0));
        check({tag, "_addr"}, 64'(addr_bad), 64'(0));
        got  = bus.res_data;
        held = bus.res_data;
        if (hold > 0) begin
            bad = 0;
            for (int i = 0; i < hold; i++) begin
                @(posedge clk); #1;
                if (!bus.res_valid || bus.res_data !== held || bus.cmd_ready || bus.res_err !== terr)
                    bad++;
            end
            check({tag, "_hold_stable"}, 64'(bad), 64'(0));
            bus.res_ready = 1'b1;
        end
        @(posedge clk); #1;
        check({tag, "_release"}, 64'({bus.res_valid, bus.res_err, bus.cmd_ready}), 64'(3'b001));
    endtask

    task automatic start_and_reach_wait(input logic [AW-1:0] ba, input int len);
        int n;
        bus.cmd_valid  = 1'b1;
        bus.cmd_base_a = ba;
        bus.cmd_base_b = ba;
        bus.cmd_len    = 9'(len);
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        n = 0;
        while (!bus.mac_start && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("reach_issue", 64'(bus.mac_start), 64'(1));
        @(posedge clk); #1;
    endtask

    initial begin
        logic [ACW-1:0] r;
        int bad;
        bus.cmd_valid  = 1'b0;
        bus.cmd_base_a = '0;
        bus.cmd_base_b = '0;
        bus.cmd_len    = '0;
        bus.res_ready  = 1'b1;
        m_acc = '0; m_cnt = 0; m_pa = '0; m_pb = '0; stray_q = 1'b0;
        for (int i = 0; i < 256; i++) begin
            mem_a[i] = '0;
            mem_b[i] = '0;
        end
        #12;
        check("rst_outputs",
              64'({bus.cmd_ready, busy, bus.mac_start, bus.mac_clr_acc, bus.mem_rd_en,
                   bus.res_valid, bus.res_err}), 64'(7'b1000000));
        check("rst_res_data", 64'(bus.res_data), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic: {1,2,3}.{4,5,6} = 32 with 17-cycle MAC
        mem_a[8'h10] = 16'd1; mem_a[8'h11] = 16'd2; mem_a[8'h12] = 16'd3;
        mem_b[8'h20] = 16'd4; mem_b[8'h21] = 16'd5; mem_b[8'h22] = 16'd6;
        fixed_delay = 17;
        run_cmd("basic", 8'h10, 8'h20, 3, -1, 1'b0, 0, r);
        check("basic_const", 64'(r), 64'(32));

        // Signed operands with address wrap
        mem_a[8'hFF] = 16'hFFFD; mem_a[8'h00] = 16'h0002;
        mem_b[8'hFE] = 16'h0007; mem_b[8'hFF] = 16'h0003;
        fixed_delay = 0;
        run_cmd("wrap", 8'hFF, 8'hFE, 2, -1, 1'b0, 0, r);
        check("wrap_const", 64'(r), 64'(40'hFF_FFFF_FFF1));

        run_cmd("zero_len", 8'h33, 8'h44, 0, -1, 1'b0, 0, r);

        // Timeout on the second element, stray mac_ready pulses in CAPTURE
        fill_random();
        run_cmd("timeout", 8'h80, 8'h90, 3, 1, 1'b1, 0, r);

        // Randomized commands
        for (int t = 0; t < 4; t++) begin
            fill_random();
            run_cmd("rand", 8'($urandom), 8'($urandom), int'($urandom_range(8, 1)),
                    -1, t[0], 0, r);
        end

        fill_random();
        run_cmd("backpressure", 8'($urandom), 8'($urandom), 4, -1, 1'b0, 10, r);

        fixed_delay = 1;
        run_cmd("full_len", 8'hC0, 8'h05, 256, -1, 1'b0, 0, r);

        // Abort in WAIT: back to IDLE, no result, next command correct
        fixed_delay = 30;
        start_and_reach_wait(8'h40, 5);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_idle", 64'({bus.cmd_ready, busy}), 64'(2'b10));
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (bus.res_valid || !bus.cmd_ready) bad++;
        end
        check("abort_no_result", 64'(bad), 64'(0));
        fixed_delay = 0;
        fill_random();
        run_cmd("after_abort", 8'h12, 8'h34, 5, -1, 1'b0, 0, r);

        // Asynchronous reset mid-WAIT
        fixed_delay = 30;
        start_and_reach_wait(8'h50, 4);
        #2 rst_n = 1'b0;
        #1;
        check("arst_outputs",
              64'({bus.cmd_ready, busy, bus.mac_start, bus.mac_clr_acc, bus.mem_rd_en,
                   bus.res_valid, bus.res_err}), 64'(7'b1000000));
        check("arst_regs", 64'({bus.res_data, bus.mac_a}), 64'(0));
        repeat (40) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("arst_release", 64'(bus.cmd_ready), 64'(1));
        fixed_delay = 0;
        fill_random();
        run_cmd("after_reset", 8'hF0, 8'h0A, 6, -1, 1'b1, 0, r);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mac_dot_sequencer.md
Name: mac_dot_sequencer

Overview:
- Command-driven controller that computes one signed dot product per command on the MAC unit (Booth multiplier plus 40-bit accumulator).
- Accepts a command {base_a, base_b, len} and clears the accumulator.
- For each element pair, reads operands from a dual-read operand memory, issues one MAC start, and waits for MAC completion.
- Returns the final 40-bit accumulator value through a valid/ready result port.
- Sits between the host/command logic and the MAC unit; it is the only driver of the MAC control and data inputs.

Parameters:
- DATA_WIDTH, 16, operand width; must match the MAC unit.
- ADDR_WIDTH, 8, operand memory address width; len is ADDR_WIDTH+1 bits.
- ACC_WIDTH, 40, accumulator/result width.
- TIMEOUT_CYCLES, 64, maximum WAIT cycles per element before an error is declared.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- abort  in  1  synchronous abort; returns to IDLE.
- cmd_valid  in  1  command valid.
- cmd_ready  out  1  high iff state==IDLE.
- cmd_base_a  in  ADDR_WIDTH  start address of vector A.
- cmd_base_b  in  ADDR_WIDTH  start address of vector B.
- cmd_len  in  ADDR_WIDTH+1  element count, 0..2^ADDR_WIDTH.
- mem_rd_en  out  1  operand read strobe.
- mem_addr_a  out  ADDR_WIDTH  A read address.
- mem_addr_b  out  ADDR_WIDTH  B read address.
- mem_rdata_a  in  DATA_WIDTH  A read data, valid 1 cycle after mem_rd_en.
- mem_rdata_b  in  DATA_WIDTH  B read data, valid 1 cycle after mem_rd_en.
- mac_start  out  1  single-cycle MAC start pulse.
- mac_clr_acc  out  1  single-cycle accumulator clear.
- mac_a  out  DATA_WIDTH  multiplicand to MAC.
- mac_b  out  DATA_WIDTH  multiplier to MAC.
- mac_ready  in  1  MAC operation done (product accumulated on this cycle).
- mac_acc  in  ACC_WIDTH  MAC accumulator value.
- res_valid  out  1  result valid.
- res_ready  in  1  result accepted.
- res_data  out  ACC_WIDTH  dot-product result.
- res_err  out  1  result terminated by timeout.
- busy  out  1  high iff state!=IDLE.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE; idx, operand registers, timeout counter and res_data go to 0.
  - mac_start, mac_clr_acc, mem_rd_en, res_valid, res_err, busy are 0; cmd_ready is 1.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid: latch base_a, base_b and len; set idx=0; go to CLEAR.
- CLEAR:
  - mac_clr_acc=1 for exactly 1 cycle.
  - If len==0, go to SETTLE; otherwise go to FETCH.
- FETCH:
  - mem_rd_en=1; mem_addr_a=base_a+idx and mem_addr_b=base_b+idx, modulo 2^ADDR_WIDTH (addresses wrap).
  - Go to CAPTURE.
- CAPTURE:
  - Register mem_rdata_a/b into mac_a/mac_b.
  - mac_a/mac_b hold until the next CAPTURE.
  - Go to ISSUE.
- ISSUE:
  - mac_start=1 for 1 cycle; clear the timeout counter.
  - Go to WAIT.
- WAIT:
  - mac_ready is sampled only in this state; mac_ready in any other state is ignored.
  - On the first cycle with mac_ready=1: idx++. If the new idx==len, go to SETTLE; otherwise go to FETCH.
  - Otherwise the counter increments. When the counter reaches TIMEOUT_CYCLES, set the error flag and go to SETTLE.
- SETTLE:
  - 1 cycle, letting the accumulator register absorb the final product.
  - Go to RESULT, capturing res_data<=mac_acc on the transition.
- RESULT:
  - res_valid=1; res_data and res_err are stable.
  - On res_ready: go to IDLE and clear res_valid/res_err.
  - res_valid stays high indefinitely until res_ready.
- Latency:
  - Per element: 3 cycles (FETCH, CAPTURE, ISSUE) plus WAIT cycles up to and including the mac_ready cycle.
  - Command accept to res_valid: 1 + Σ(per-element) + 2.
- Arithmetic:
  - The sequencer does no arithmetic on data; res_data is mac_acc verbatim (signed, sign-extended by the MAC).
  - The length compare uses ADDR_WIDTH+1 bits, so len=2^ADDR_WIDTH is legal and wraps the addresses.
- abort (any state, highest priority after reset):
  - Next state is IDLE; no result is produced.
  - Any in-flight MAC completion is ignored.
  - The accumulator is not cleared by abort; the next command's CLEAR does that.
- A cmd_valid while busy is not accepted (cmd_ready=0); the command must be held by the sender.
- Reset mid-operation returns to the reset values immediately; no partial result is emitted.

Test Plan:
- Basic: A={1,2,3} at 0x10, B={4,5,6} at 0x20, len=3; MAC returns mac_ready after 17 cycles -> res_valid with res_data=32, res_err=0; exactly 3 mac_start pulses and 1 mac_clr_acc pulse, issued before the first mac_start.
- Signed/wrap: base_a=0xFF, base_b=0xFE, len=2, A={0xFFFD,0x0002}, B={0x0007,0x0003} -> reads at addresses (FF,FE),(00,FF); res_data=40'hFF_FFFF_FFF1 (-15).
- Zero length: len=0 -> one mac_clr_acc, no mem_rd_en, no mac_start; res_valid 3 cycles after accept with res_data=0.
- Timeout: mac_ready held 0 after the second mac_start, TIMEOUT_CYCLES=64 -> res_valid with res_err=1 and res_data equal to the accumulator after the first product; a stray mac_ready outside WAIT causes no idx change.
- Backpressure/abort: hold res_ready=0 for 10 cycles -> res_valid and res_data stable, cmd_ready=0. Assert abort in WAIT -> IDLE next cycle, res_valid never asserts, and the next command computes a correct result.
- Reset: drop rst_n mid-WAIT -> all outputs go to their reset values asynchronously; cmd_ready=1 after release.
